// File: rtl/prog_rom_arbiter.sv
// -----------------------------------------------------------------------------
// prog_rom_arbiter
//
// Shares the single-port synchronous program ROM between two requesters. The
// first is the MCU instruction fetch, which is the primary requester. The
// second is the debug/loader readback port. The block drives ROM_ADDR and
// routes ROM_DATA back to whichever requester issued the read one cycle
// earlier.
//
// Each cycle carries at most one ROM slot: FETCH, DBG or NONE.
// Fetch normally wins the slot. A pending debug read may be passed over for
// at most MAX_WAIT fetch slots, and then it takes the slot. When MAX_WAIT is
// 0, a pending debug read always wins.
//
// Optional feature: define DBG_BURST_EN to enable multi-word debug bursts of
// DBG_LEN+1 words at consecutive addresses. The address wraps modulo
// 2^ADDR_W. In the default build every debug transfer is exactly one word and
// DBG_LEN is ignored.
//
// Ports
//   CLK          in   system clock, all logic on posedge
//   RST          in   synchronous active-high reset
//   FETCH_REQ    in   fetch wants a ROM read this cycle
//   FETCH_ADDR   in   fetch address
//   FETCH_STALL  out  fetch request not issued this cycle (combinational)
//   FETCH_VALID  out  FETCH_IR valid this cycle
//   FETCH_IR     out  fetched word, 0 when not valid
//   DBG_REQ      in   4-phase level request, held until DBG_DONE
//   DBG_ADDR     in   debug start address, sampled when idle
//   DBG_LEN      in   extra burst words (DBG_BURST_EN builds only)
//   DBG_VALID    out  DBG_DATA valid this cycle
//   DBG_DATA     out  readback word, 0 when not valid
//   DBG_DONE     out  1-cycle pulse with the last DBG_VALID
//   ROM_ADDR     out  address to ROM
//   ROM_DATA     in   ROM word, valid 1 cycle after ROM_ADDR is sampled
// -----------------------------------------------------------------------------
module prog_rom_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 18,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FETCH_REQ,
  input  logic [ADDR_W-1:0] FETCH_ADDR,
  output logic              FETCH_STALL,
  output logic              FETCH_VALID,
  output logic [DATA_W-1:0] FETCH_IR,
  input  logic              DBG_REQ,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [7:0]        DBG_LEN,
  output logic              DBG_VALID,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic              DBG_DONE,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [DATA_W-1:0] ROM_DATA
);

  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_DRAIN, D_RELEASE} dbg_state_t;
  typedef enum logic [1:0] {S_NONE, S_FETCH, S_DBG} slot_t;

  // The counter must hold the value 0..MAX_WAIT. It is kept at least 1 bit
  // wide so that MAX_WAIT = 0 still elaborates.
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  dbg_state_t        state;
  slot_t             slot;
  slot_t             tag_q;      // slot issued last cycle; tags ROM_DATA now
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] dbg_addr;
  logic              last_word;  // current DBG slot is the final word of the transfer

`ifdef DBG_BURST_EN
  logic [8:0] remaining;         // words still to issue, 1..256
  assign last_word = (remaining == 9'd1);
`else
  assign last_word = 1'b1;
  // Every transfer is a single word, so the length input has no effect.
  logic unused_dbg_len;
  assign unused_dbg_len = ^DBG_LEN;
`endif

  // Slot selection. Debug wins only when fetch is idle or has used up its
  // allowance of consecutive slots.
  // NOTE: a default is assigned before any branch, so that slot is driven on
  // every path and no latch is inferred.
  always_comb begin
    slot = S_NONE;
    if (state == D_ISSUE && (!FETCH_REQ || wait_cnt == WAIT_MAX))
      slot = S_DBG;
    else if (FETCH_REQ)
      slot = S_FETCH;
  end

  // When there is no slot, ROM_ADDR still follows FETCH_ADDR. The ROM read
  // result is harmless because tag_q marks that data as unowned.
  assign ROM_ADDR    = (slot == S_DBG) ? dbg_addr : FETCH_ADDR;
  assign FETCH_STALL = FETCH_REQ && (slot == S_DBG);

  assign FETCH_VALID = (tag_q == S_FETCH);
  assign DBG_VALID   = (tag_q == S_DBG);
  assign FETCH_IR    = FETCH_VALID ? ROM_DATA : '0;
  assign DBG_DATA    = DBG_VALID   ? ROM_DATA : '0;
  assign DBG_DONE    = (state == D_DRAIN);

  // NOTE: all state is updated with non-blocking assignments. Every read in
  // this block therefore sees the value from before the clock edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= D_IDLE;
      tag_q    <= S_NONE;
      wait_cnt <= '0;
      dbg_addr <= '0;
`ifdef DBG_BURST_EN
      remaining <= '0;
`endif
    end else begin
      tag_q <= slot;

      // Count the fetch slots taken while debug waits. The counter clears
      // when debug finally gets a slot.
      if (slot == S_DBG)
        wait_cnt <= '0;
      else if (state == D_ISSUE && slot == S_FETCH && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 1'b1;

      unique case (state)
        D_IDLE: begin
          if (DBG_REQ) begin
            dbg_addr <= DBG_ADDR;
`ifdef DBG_BURST_EN
            remaining <= {1'b0, DBG_LEN} + 9'd1;
`endif
            state <= D_ISSUE;
          end
        end
        D_ISSUE: begin
          if (slot == S_DBG) begin
            dbg_addr <= dbg_addr + 1'b1;   // wraps naturally at 2^ADDR_W
`ifdef DBG_BURST_EN
            remaining <= remaining - 9'd1;
`endif
            if (last_word)
              state <= D_DRAIN;
          end
        end
        D_DRAIN:   state <= D_RELEASE;
        D_RELEASE: if (!DBG_REQ) state <= D_IDLE;
        default:   state <= D_IDLE;
      endcase
    end
  end

endmodule
